// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM feeder blocks.
//   feat_type_e  : packet type presented to the core (SYS_type / BR_type)
//   pack_state_e : issue FSM states of the input packer
//   DATA_W       : core data word width (512)
//   BEAT_W       : feature beat width (64)
//   ZERO_DATA    : quantized zero byte used to pad unfilled bytes
package lstm_pkg;

  localparam int DATA_W = 512;
  localparam int BEAT_W = 64;
  localparam logic [7:0] ZERO_DATA = 8'd128;

  typedef enum logic {
    SYS_type = 1'b0,
    BR_type  = 1'b1
  } feat_type_e;

  typedef enum logic [1:0] {
    ISSUE    = 2'd0,
    WAIT_ACK = 2'd1,
    ERR      = 2'd2
  } pack_state_e;

endpackage

// File: rtl/lstm_pack_slot.sv
// One 512-bit packet slot of the input packer's ping-pong buffer.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   start_en    : first beat of a packet: pad the slot, write beat at 0, latch type
//   wr_en       : later beat of a packet: write beat at idx
//   idx         : beat index inside the slot
//   beat        : 64-bit beat data
//   start_type  : packet type captured with the first beat
//   set_full    : packet complete, slot ready for issue
//   clr_full    : slot content handed to the core, slot free again
//   data        : slot contents
//   full        : slot holds a complete packet
//   pkt_type    : type of the packet in the slot
module lstm_pack_slot
  import lstm_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = ZERO_DATA,
  parameter int         IDX_W    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_en,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  idx,
  input  logic [BEAT_W-1:0] beat,
  input  feat_type_e        start_type,
  input  logic              set_full,
  input  logic              clr_full,
  output logic [DATA_W-1:0] data,
  output logic              full,
  output feat_type_e        pkt_type
);

  // The first beat overwrites the whole slot, so stale bytes from the
  // previous packet never leak into a short packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data     <= '0;
      full     <= 1'b0;
      pkt_type <= SYS_type;
    end else begin
      if (start_en) begin
        data     <= {{((DATA_W - BEAT_W) / 8){PAD_BYTE}}, beat};
        pkt_type <= start_type;
      end else if (wr_en) begin
        data[int'(idx) * BEAT_W +: BEAT_W] <= beat;
      end
      // Fill and issue never target the same slot in one cycle: fill only
      // writes an empty slot, issue only reads a full one.
      if (set_full) begin
        full <= 1'b1;
      end else if (clr_full) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/lstm_input_packer.sv
// Upstream feeder of the LSTM core. Packs 64-bit feature beats into 512-bit
// words in a two-slot ping-pong buffer and issues them in order to the core,
// paced by the core's done signal.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   iFeat_valid/oFeat_ready : beat handshake
//   iFeat_type      : 0=SYS, 1=BRANCH, sampled on the first beat of a packet
//   iFeat_last      : closes a BRANCH packet early
//   iFeat_data      : beat data
//   iLstm_done      : core idle/ready
//   oNext_valid     : one-cycle issue strobe
//   oType, oData    : issued packet, held until the next issue
//   oShort          : pulse, BRANCH packet closed early by iFeat_last
//   oErr            : sticky, core failed to drop done after an issue
//   oSys_cnt/oBr_cnt: issued packet counters
// Configuration macro: LSTM_PACK_STATS_EN enables the issue counters;
// without it the counter ports are tied to zero.
module lstm_input_packer
  import lstm_pkg::*;
#(
  parameter int         BR_BEATS    = 8,
  parameter logic [7:0] PAD_BYTE    = ZERO_DATA,
  parameter logic [9:0] ACK_TIMEOUT = 10'd1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iFeat_valid,
  output logic              oFeat_ready,
  input  logic              iFeat_type,
  input  logic              iFeat_last,
  input  logic [BEAT_W-1:0] iFeat_data,
  input  logic              iLstm_done,
  output logic              oNext_valid,
  output logic              oType,
  output logic [DATA_W-1:0] oData,
  output logic              oShort,
  output logic              oErr,
  output logic [15:0]       oSys_cnt,
  output logic [15:0]       oBr_cnt
);

  localparam int IDX_W = $clog2(BR_BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BR_BEATS - 1);

  logic              wr_sel;
  logic              rd_sel;
  logic [IDX_W-1:0]  beat_idx;
  logic [1:0]        full;
  logic [DATA_W-1:0] slot_data [2];
  feat_type_e        slot_type [2];
  pack_state_e       state;
  pack_state_e       state_nxt;
  logic [9:0]        ack_cnt;
  logic              accept;
  logic              first_beat;
  logic              pkt_is_br;
  logic              pkt_done;
  logic              issue;
  feat_type_e        cur_type;

  assign oErr        = (state == ERR);
  assign oFeat_ready = !full[wr_sel] && !oErr;
  assign accept      = iFeat_valid && oFeat_ready;
  assign first_beat  = (beat_idx == '0);

  // The packet type only comes from the wire on the first beat; later beats
  // use the type latched in the slot being filled.
  assign cur_type  = first_beat ? feat_type_e'(iFeat_type) : slot_type[wr_sel];
  assign pkt_is_br = (cur_type == BR_type);
  assign pkt_done  = accept && (!pkt_is_br || iFeat_last || (beat_idx == LAST_IDX));

  for (genvar s = 0; s < 2; s++) begin : g_slot
    lstm_pack_slot #(
      .PAD_BYTE (PAD_BYTE),
      .IDX_W    (IDX_W)
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .start_en   (accept && first_beat && (wr_sel == 1'(s))),
      .wr_en      (accept && !first_beat && (wr_sel == 1'(s))),
      .idx        (beat_idx),
      .beat       (iFeat_data),
      .start_type (feat_type_e'(iFeat_type)),
      .set_full   (pkt_done && (wr_sel == 1'(s))),
      .clr_full   (issue && (rd_sel == 1'(s))),
      .data       (slot_data[s]),
      .full       (full[s]),
      .pkt_type   (slot_type[s])
    );
  end

  // Fill side: track the beat position and hand a completed slot over to the
  // issue side by flipping wr_sel. A reset drops any half-built packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_sel   <= 1'b0;
      beat_idx <= '0;
      oShort   <= 1'b0;
    end else begin
      oShort <= 1'b0;
      if (pkt_done) begin
        wr_sel   <= ~wr_sel;
        beat_idx <= '0;
        oShort   <= pkt_is_br && iFeat_last && (beat_idx != LAST_IDX);
      end else if (accept) begin
        beat_idx <= beat_idx + 1'b1;
      end
    end
  end

  // Issue decision. WAIT_ACK holds off a second issue until the core has
  // visibly dropped done, since done is still high right after the strobe.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    unique case (state)
      ISSUE: begin
        if (full[rd_sel] && iLstm_done) begin
          issue     = 1'b1;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!iLstm_done) begin
          state_nxt = ISSUE;
        end else if (ack_cnt == ACK_TIMEOUT) begin
          state_nxt = ERR;
        end
      end
      ERR: begin
        state_nxt = ERR;
      end
      default: begin
        state_nxt = ISSUE;
      end
    endcase
  end

  // Issue register: state, acknowledge timer and the held word to the core.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ISSUE;
      ack_cnt     <= '0;
      rd_sel      <= 1'b0;
      oNext_valid <= 1'b0;
      oType       <= 1'b0;
      oData       <= '0;
    end else begin
      state       <= state_nxt;
      oNext_valid <= issue;
      if (state == WAIT_ACK && iLstm_done) begin
        ack_cnt <= ack_cnt + 1'b1;
      end else begin
        ack_cnt <= '0;
      end
      if (issue) begin
        oData  <= slot_data[rd_sel];
        oType  <= slot_type[rd_sel];
        rd_sel <= ~rd_sel;
      end
    end
  end

`ifdef LSTM_PACK_STATS_EN
  logic [15:0] sys_cnt;
  logic [15:0] br_cnt;

  // Per-type issue counters; they wrap naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sys_cnt <= '0;
      br_cnt  <= '0;
    end else if (issue) begin
      if (slot_type[rd_sel] == BR_type) begin
        br_cnt <= br_cnt + 1'b1;
      end else begin
        sys_cnt <= sys_cnt + 1'b1;
      end
    end
  end

  assign oSys_cnt = sys_cnt;
  assign oBr_cnt  = br_cnt;
`else
  assign oSys_cnt = '0;
  assign oBr_cnt  = '0;
`endif

endmodule

// File: tb/tb_lstm_input_packer.sv
// Self-checking bench for lstm_input_packer. A byte-level packet model builds
// the expected 512-bit words; a monitor pops them in order at every issue.
// Honours LSTM_PACK_STATS_EN for the counter expectations.
module tb_lstm_input_packer;

  typedef struct {
    logic         ptype;
    logic [511:0] data;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         iFeat_valid;
  logic         oFeat_ready;
  logic         iFeat_type;
  logic         iFeat_last;
  logic [63:0]  iFeat_data;
  logic         iLstm_done;
  logic         oNext_valid;
  logic         oType;
  logic [511:0] oData;
  logic         oShort;
  logic         oErr;
  logic [15:0]  oSys_cnt;
  logic [15:0]  oBr_cnt;

  int           checks;
  int           errors;
  exp_t         exp_q[$];
  logic [511:0] last_data;
  logic         last_type;
  int           sys_issued;
  int           br_issued;
  int           core_mode;
  int           busy;

  lstm_input_packer dut (
    .clk         (clk),
    .reset       (reset),
    .iFeat_valid (iFeat_valid),
    .oFeat_ready (oFeat_ready),
    .iFeat_type  (iFeat_type),
    .iFeat_last  (iFeat_last),
    .iFeat_data  (iFeat_data),
    .iLstm_done  (iLstm_done),
    .oNext_valid (oNext_valid),
    .oType       (oType),
    .oData       (oData),
    .oShort      (oShort),
    .oErr        (oErr),
    .oSys_cnt    (oSys_cnt),
    .oBr_cnt     (oBr_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected core word: all bytes zero-coded, then the written beats laid in.
  function automatic logic [511:0] expectWord(input logic ftype, input logic [63:0] beats [8], input int n);
    logic [7:0]   bytes [64];
    logic [511:0] w;
    int           used;
    used = ftype ? n : 1;
    for (int i = 0; i < 64; i++) bytes[i] = 8'd128;
    for (int k = 0; k < used; k++)
      for (int b = 0; b < 8; b++) bytes[8 * k + b] = beats[k][8 * b +: 8];
    for (int i = 0; i < 64; i++) w[8 * i +: 8] = bytes[i];
    return w;
  endfunction

  // Core model: mode 0 drops done for a random busy time after each strobe,
  // mode 1 holds done low, mode 2 holds done high.
  initial begin
    iLstm_done = 1'b1;
    busy = 0;
    forever begin
      @(posedge clk);
      #1;
      case (core_mode)
        0: begin
          if (oNext_valid) busy = $urandom_range(1, 4);
          if (busy > 0) begin
            iLstm_done = 1'b0;
            busy--;
          end else begin
            iLstm_done = 1'b1;
          end
        end
        1: iLstm_done = 1'b0;
        default: iLstm_done = 1'b1;
      endcase
    end
  end

  // Monitor: each strobe must carry the oldest outstanding packet; between
  // strobes the word to the core must not move.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (oNext_valid) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_issue", 512'(oNext_valid), 512'(0));
          end else begin
            e = exp_q.pop_front();
            checkOutput("issue_type", 512'(oType), 512'(e.ptype));
            checkOutput("issue_data", oData, e.data);
            last_data = e.data;
            last_type = e.ptype;
            if (e.ptype) br_issued++;
            else sys_issued++;
          end
        end else begin
          checkOutput("data_hold", oData, last_data);
          checkOutput("type_hold", 512'(oType), 512'(last_type));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyReset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    iFeat_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    last_data  = '0;
    last_type  = 1'b0;
    sys_issued = 0;
    br_issued  = 0;
  endtask

  task automatic checkResetState;
    checkOutput("rst_next_valid", 512'(oNext_valid), 512'(0));
    checkOutput("rst_type", 512'(oType), 512'(0));
    checkOutput("rst_data", oData, 512'(0));
    checkOutput("rst_short", 512'(oShort), 512'(0));
    checkOutput("rst_err", 512'(oErr), 512'(0));
    checkOutput("rst_ready", 512'(oFeat_ready), 512'(1));
    checkOutput("rst_sys_cnt", 512'(oSys_cnt), 512'(0));
    checkOutput("rst_br_cnt", 512'(oBr_cnt), 512'(0));
  endtask

  // One beat: present it and hold it until the packer takes it.
  task automatic applyStimulus(input logic ftype, input logic last, input logic [63:0] data);
    int waited;
    waited = 0;
    iFeat_valid = 1'b1;
    iFeat_type  = ftype;
    iFeat_last  = last;
    iFeat_data  = data;
    forever begin
      @(negedge clk);
      if (oFeat_ready) break;
      waited++;
      if (waited > 3000) begin
        checkOutput("ready_timeout", 512'(oFeat_ready), 512'(1));
        break;
      end
    end
    @(posedge clk);
    #1;
    iFeat_valid = 1'b0;
    iFeat_data  = {$urandom, $urandom};
  endtask

  // A whole packet: register its expected word, send the beats, check oShort.
  task automatic sendPacket(input logic ftype, input logic [63:0] beats [8], input int n, input logic last_final);
    exp_t e;
    int   used;
    logic exp_short;
    used      = ftype ? n : 1;
    e.ptype   = ftype;
    e.data    = expectWord(ftype, beats, n);
    exp_short = ftype && (n < 8);
    exp_q.push_back(e);
    for (int k = 0; k < used; k++) begin
      applyStimulus((k == 0) ? ftype : 1'($urandom), (k == used - 1) ? last_final : 1'b0, beats[k]);
      if (k < used - 1) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    @(negedge clk);
    checkOutput("short_pulse", 512'(oShort), 512'(exp_short));
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain;
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    checkOutput("drain", 512'(exp_q.size()), 512'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic checkStats;
`ifdef LSTM_PACK_STATS_EN
    checkOutput("sys_cnt", 512'(oSys_cnt), 512'(sys_issued[15:0]));
    checkOutput("br_cnt", 512'(oBr_cnt), 512'(br_issued[15:0]));
`else
    checkOutput("sys_cnt_tied", 512'(oSys_cnt), 512'(0));
    checkOutput("br_cnt_tied", 512'(oBr_cnt), 512'(0));
`endif
  endtask

  initial begin
    logic [63:0] beats [8];
    exp_t        e;
    int          n;
    logic        ftype;
    checks      = 0;
    errors      = 0;
    core_mode   = 0;
    reset       = 1'b1;
    iFeat_valid = 1'b0;
    iFeat_type  = 1'b0;
    iFeat_last  = 1'b0;
    iFeat_data  = '0;
    last_data   = '0;
    last_type   = 1'b0;
    sys_issued  = 0;
    br_issued   = 0;

    $display("[TB] reset state");
    applyReset();
    checkResetState();

    $display("[TB] single SYS beat, issue latency");
    for (int i = 0; i < 8; i++) beats[i] = '0;
    beats[0] = 64'h0102030405060708;
    e.ptype = 1'b0;
    e.data  = expectWord(1'b0, beats, 1);
    exp_q.push_back(e);
    applyStimulus(1'b0, 1'b0, beats[0]);
    @(negedge clk);
    checkOutput("lat_t1", 512'(oNext_valid), 512'(0));
    @(negedge clk);
    checkOutput("lat_t2", 512'(oNext_valid), 512'(1));
    checkOutput("sys_word", oData, {{56{8'h80}}, 64'h0102030405060708});
    @(posedge clk);
    #1;
    waitDrain();
    checkStats();

    $display("[TB] full BRANCH packet");
    for (int i = 0; i < 8; i++) beats[i] = {8{8'(8'h11 * (i + 1))}};
    sendPacket(1'b1, beats, 8, 1'b1);
    waitDrain();
    checkOutput("br_lo", 512'(oData[63:0]), 512'(64'h1111111111111111));
    checkOutput("br_hi", 512'(oData[511:448]), 512'(64'h8888888888888888));
    checkOutput("br_type", 512'(oType), 512'(1));

    $display("[TB] short BRANCH packet");
    for (int i = 0; i < 8; i++) beats[i] = {$urandom, $urandom};
    sendPacket(1'b1, beats, 3, 1'b1);
    waitDrain();
    checkOutput("short_pad", 512'(oData[511:192]), 512'({40{8'h80}}));
    checkStats();

    $display("[TB] back-pressure with core busy");
    core_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      beats[i] = {$urandom, $urandom};
      e.ptype = 1'b0;
      e.data  = {{56{8'h80}}, beats[i]};
      exp_q.push_back(e);
    end
    applyStimulus(1'b0, 1'b0, beats[0]);
    applyStimulus(1'b0, 1'b0, beats[1]);
    iFeat_valid = 1'b1;
    iFeat_type  = 1'b0;
    iFeat_last  = 1'b0;
    iFeat_data  = beats[2];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("stall_ready", 512'(oFeat_ready), 512'(0));
      checkOutput("stall_no_issue", 512'(oNext_valid), 512'(0));
    end
    @(posedge clk);
    #1;
    core_mode = 0;
    applyStimulus(1'b0, 1'b0, beats[2]);
    waitDrain();
    checkStats();

    $display("[TB] acknowledge timeout");
    core_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    beats[0] = {$urandom, $urandom};
    e.ptype = 1'b0;
    e.data  = {{56{8'h80}}, beats[0]};
    exp_q.push_back(e);
    applyStimulus(1'b0, 1'b0, beats[0]);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!oNext_valid && n < 10);
    checkOutput("timeout_issue_seen", 512'(oNext_valid), 512'(1));
    repeat (1023) @(negedge clk);
    checkOutput("err_not_early", 512'(oErr), 512'(0));
    @(negedge clk);
    checkOutput("err_set", 512'(oErr), 512'(1));
    checkOutput("err_ready", 512'(oFeat_ready), 512'(0));
    @(posedge clk);
    #1;
    iFeat_valid = 1'b1;
    iFeat_data  = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("err_sticky", 512'(oErr), 512'(1));
      checkOutput("err_no_accept", 512'(oFeat_ready), 512'(0));
    end
    applyReset();
    checkResetState();
    core_mode = 0;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] reset in the middle of a BRANCH packet");
    for (int i = 0; i < 8; i++) beats[i] = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, beats[i]);
    iFeat_valid = 1'b1;
    iFeat_type  = 1'b1;
    iFeat_data  = beats[4];
    applyReset();
    checkResetState();
    beats[0] = {$urandom, $urandom};
    sendPacket(1'b0, beats, 1, 1'b0);
    waitDrain();
    checkOutput("post_rst_type", 512'(oType), 512'(0));
    checkOutput("post_rst_data", 512'(oData[63:0]), 512'(beats[0]));
    checkStats();

    $display("[TB] random packets");
    for (int p = 0; p < 40; p++) begin
      ftype = 1'($urandom);
      n = $urandom_range(1, 8);
      for (int i = 0; i < 8; i++) beats[i] = {$urandom, $urandom};
      sendPacket(ftype, beats, n, (ftype && n < 8) ? 1'b1 : 1'($urandom));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    waitDrain();
    checkStats();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
